progress_ticker: RTL and testbench

Parametrised progress-bar sequencer for the playback/record display path. It sits between the menu controller and the display renderer. It turns the active menu mode into a stepped progress index that advances once per programmable tick interval, with pause, restart and end-of-track handling. Everything runs in the single system clock domain; no derived clocks are generated.

---
 rtl/progress_ticker.sv | 192 +++++++++++++++++++
 tb/tb_progress_ticker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/progress_ticker.sv
// -----------------------------------------------------------------------------
// progress_ticker
//
// Progress-bar sequencer for the playback/record display path. It converts
// the active menu mode into a stepped progress index. The index advances once
// every TICK_CYCLES clocks. Pause, restart and end-of-track are handled here.
// Single clock domain. All outputs are registered.
//
// Build option:
//   PROGRESS_LOOP_EN : when defined, play mode wraps STEPS->0 with a wrap
//                      pulse instead of saturating. Record mode always
//                      saturates. When undefined, wrap is tied low.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   menu     in   2-bit mode: 00 idle, 01 play, 10 record, 11 reserved (idle)
//   pause    in   level; freezes prescaler and index while high
//   restart  in   one-cycle pulse; index and prescaler return to 0, mode kept
//   idx      out  current progress step, 0..STEPS
//   tick     out  one-cycle pulse in the first cycle a new idx is visible
//   done     out  high while idx is held at STEPS
//   wrap     out  one-cycle pulse on STEPS->0 rollover (loop builds only)
//   active   out  high in RUN or PAUSE
// -----------------------------------------------------------------------------
module progress_ticker #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int STEPS       = 20,
    parameter int IDX_W       = 6,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       menu,
    input  logic             pause,
    input  logic             restart,
    output logic [IDX_W-1:0] idx,
    output logic             tick,
    output logic             done,
    output logic             wrap,
    output logic             active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] presc, presc_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             tick_nx;
    logic             done_nx;
    logic             active_nx;
    logic [1:0]       menu_q;

    logic mode_act;   // menu selects play or record
    logic mode_chg;   // menu differs from last cycle's value
    logic expire;     // prescaler at its terminal count
    logic at_last;    // index already saturated at STEPS

`ifdef PROGRESS_LOOP_EN
    logic wrap_nx;
`endif

    assign mode_act = (menu == 2'b01) || (menu == 2'b10);
    assign mode_chg = (menu != menu_q);
    assign expire   = (presc == LAST_CNT);
    assign at_last  = (idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state / next-output logic.
    // Priority: mode change, restart, pause, expiry. Reset is in the register
    // process. A clear from a mode change or restart discards any expiry in
    // the same cycle, so neither tick nor wrap fires then.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        idx_nx   = idx;
        tick_nx  = 1'b0;
`ifdef PROGRESS_LOOP_EN
        wrap_nx  = 1'b0;
`endif

        if (mode_chg) begin
            presc_nx = '0;
            idx_nx   = '0;
            state_nx = mode_act ? S_RUN : S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    presc_nx = '0;
                    idx_nx   = '0;
                    if (mode_act) state_nx = S_RUN;
                end

                // In PAUSE, an unpaused cycle counts exactly like RUN. Counting
                // therefore resumes on the first cycle pause is low. An expiry
                // held back by pause fires then, too.
                S_RUN, S_PAUSE: begin
                    if (restart) begin
                        presc_nx = '0;
                        idx_nx   = '0;
                        state_nx = S_RUN;
                    end else if (pause) begin
                        state_nx = S_PAUSE;
                    end else begin
                        state_nx = S_RUN;
                        if (expire) begin
                            presc_nx = '0;
                            if (!at_last) begin
                                idx_nx  = idx + 1'b1;
                                tick_nx = 1'b1;
                            end
`ifdef PROGRESS_LOOP_EN
                            else if (menu == 2'b01) begin
                                idx_nx  = '0;
                                tick_nx = 1'b1;
                                wrap_nx = 1'b1;
                            end
`endif
                            else begin
                                // The end was reached one interval ago; park here.
                                state_nx = S_DONE;
                            end
                        end else begin
                            presc_nx = presc + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    presc_nx = '0;
                    if (restart) begin
                        idx_nx   = '0;
                        state_nx = S_RUN;
                    end
                end

                default: begin
                    presc_nx = '0;
                    idx_nx   = '0;
                    state_nx = S_IDLE;
                end
            endcase
        end

        // done follows idx directly. It rises with the step that lands on
        // STEPS, not with entry to DONE.
        done_nx   = (idx_nx == LAST_IDX) && (state_nx != S_IDLE);
        active_nx = (state_nx == S_RUN) || (state_nx == S_PAUSE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            presc  <= '0;
            idx    <= '0;
            tick   <= 1'b0;
            done   <= 1'b0;
            active <= 1'b0;
            menu_q <= 2'b00;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            idx    <= idx_nx;
            tick   <= tick_nx;
            done   <= done_nx;
            active <= active_nx;
            menu_q <= menu;
        end
    end

`ifdef PROGRESS_LOOP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) wrap <= 1'b0;
        else        wrap <= wrap_nx;
    end
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_progress_ticker.sv
// -----------------------------------------------------------------------------
// tb_progress_ticker
//
// Directed bench for progress_ticker with TICK_CYCLES=4 and STEPS=3.
// The stimulus process drives the inputs. For every tick it expects, it
// pushes the cycle number, idx, done, wrap and active into a queue. A monitor
// runs on the falling edge. It pops and compares on each tick. A tick with no
// queued expectation is an error, and so is a wrap without a tick. Level
// checks (reset values, pause hold, DONE, IDLE) are made inline. cyc counts
// rising edges since time zero.
// -----------------------------------------------------------------------------
module tb_progress_ticker;

    localparam int TC = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] menu;
    logic       pause;
    logic       restart;
    logic [2:0] idx;
    logic       tick, done, wrap, active;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic       done;
        logic       wrap;
        logic       active;
    } exp_t;

    exp_t exp_q[$];

    progress_ticker #(
        .TICK_CYCLES(TC),
        .STEPS      (ST),
        .IDX_W      (3),
        .CNT_W      (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .menu   (menu),
        .pause  (pause),
        .restart(restart),
        .idx    (idx),
        .tick   (tick),
        .done   (done),
        .wrap   (wrap),
        .active (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push_exp(input int c, input int i, input bit d, input bit w, input bit a);
        exp_t e;
        e.cyc = c; e.idx = 3'(i); e.done = d; e.wrap = w; e.active = a;
        exp_q.push_back(e);
    endtask

    // Move to 1 time unit after rising edge number c.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_levels(input string name, input int i, input bit d, input bit a);
        chk({name, ".idx"},    32'(idx),    32'(i));
        chk({name, ".done"},   32'(done),   32'(d));
        chk({name, ".active"}, 32'(active), 32'(a));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tick @cyc %0d: idx=%0d, expected no tick", cyc, idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tick.cycle",  32'(cyc),    32'(e.cyc));
                chk("tick.idx",    32'(idx),    32'(e.idx));
                chk("tick.done",   32'(done),   32'(e.done));
                chk("tick.wrap",   32'(wrap),   32'(e.wrap));
                chk("tick.active", 32'(active), 32'(e.active));
            end
        end else if (wrap !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL stray_wrap @cyc %0d: wrap=%b, expected 0", cyc, wrap);
        end
    end

    initial begin
        rst_n = 1'b0; menu = 2'b00; pause = 1'b0; restart = 1'b0;

        // Reset state
        wait_to(3);
        chk("rst.idx",    32'(idx),    32'd0);
        chk("rst.tick",   32'(tick),   32'd0);
        chk("rst.wrap",   32'(wrap),   32'd0);
        chk_levels("rst", 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Play from IDLE: RUN after edge 5, steps at 9, 13, 17.
        wait_to(4);
        menu = 2'b01;
        push_exp(9,  1, 1'b0, 1'b0, 1'b1);
        push_exp(13, 2, 1'b0, 1'b0, 1'b1);
        push_exp(17, 3, 1'b1, 1'b0, 1'b1);
`ifdef PROGRESS_LOOP_EN
        push_exp(21, 0, 1'b0, 1'b1, 1'b1);
        wait_to(24);
        chk_levels("loop_after_wrap", 0, 1'b0, 1'b1);
`else
        wait_to(24);
        chk_levels("play_done", 3, 1'b1, 1'b0);
`endif

        // One-cycle reset, then clear to IDLE values.
        rst_n = 1'b0;
        wait_to(25);
        rst_n = 1'b1;
        chk("rst2.tick", 32'(tick), 32'd0);
        chk("rst2.wrap", 32'(wrap), 32'd0);
        chk_levels("rst2", 0, 1'b0, 1'b0);
        // menu is still 01: RUN after edge 26, first step at 30.
        push_exp(30, 1, 1'b0, 1'b0, 1'b1);
        wait_to(31);
        menu = 2'b00;
        wait_to(33);
        chk_levels("mode_drop", 0, 1'b0, 1'b0);

        // Pause at prescaler=2, idx=1 for 10 cycles.
        wait_to(34);
        menu = 2'b01;
        push_exp(39, 1, 1'b0, 1'b0, 1'b1);
        wait_to(41);
        pause = 1'b1;
        wait_to(46);
        chk_levels("paused", 1, 1'b0, 1'b1);
        wait_to(51);
        pause = 1'b0;
        push_exp(53, 2, 1'b0, 1'b0, 1'b1);

        // Restart coincident with the expiry at idx=2 (edge 57).
        wait_to(56);
        restart = 1'b1;
        wait_to(57);
        restart = 1'b0;
        wait_to(58);
        chk_levels("restart_clear", 0, 1'b0, 1'b1);
        push_exp(61, 1, 1'b0, 1'b0, 1'b1);

        // Record mode: the mode change clears, then saturates, no wrap.
        wait_to(62);
        menu = 2'b10;
        push_exp(67, 1, 1'b0, 1'b0, 1'b1);
        push_exp(71, 2, 1'b0, 1'b0, 1'b1);
        push_exp(75, 3, 1'b1, 1'b0, 1'b1);
        wait_to(82);
        chk_levels("rec_done", 3, 1'b1, 1'b0);

        // Restart out of DONE.
        restart = 1'b1;
        wait_to(83);
        restart = 1'b0;
        chk_levels("done_restart", 0, 1'b0, 1'b1);
        push_exp(87, 1, 1'b0, 1'b0, 1'b1);

        // Pause coincident with expiry (edge 91): fires at the first unpaused edge.
        wait_to(90);
        pause = 1'b1;
        wait_to(92);
        pause = 1'b0;
        push_exp(93, 2, 1'b0, 1'b0, 1'b1);

        // Back to IDLE; restart there is ignored.
        wait_to(94);
        menu = 2'b00;
        wait_to(96);
        restart = 1'b1;
        wait_to(97);
        restart = 1'b0;
        wait_to(99);
        chk_levels("idle_restart", 0, 1'b0, 1'b0);

        wait_to(110);
        chk("pending_ticks", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
